// File: rtl/hack_pkg.sv
// Shared types and sizing for the Hack word buffering blocks.
package hack_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned CNT_W  = 3;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/mux_4_way_16.sv
// Four-input, 16-bit combinational word selector.
module mux_4_way_16
  import hack_pkg::*;
(
  input  word_t      a,
  input  word_t      b,
  input  word_t      c,
  input  word_t      d,
  input  logic [1:0] sel,
  output word_t      y
);

  // Select one of four words.
  always_comb begin
    y = a;
    unique case (sel)
      2'd0:    y = a;
      2'd1:    y = b;
      2'd2:    y = c;
      default: y = d;
    endcase
  end

endmodule

// File: rtl/register_16.sv
// 16-bit storage register with load enable and asynchronous clear.
module register_16
  import hack_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  word_t d,
  output word_t q
);

  // Capture d on load; reset clears the word immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fifo_4x16.sv
// 4-entry first-word-fall-through FIFO of Hack words with valid/ready on both sides.
// The head word is read straight out of storage through the mux, so a word written
// at one edge is visible right after that edge, with no in_data-to-out_data bypass.
module fifo_4x16
  import hack_pkg::*;
#(
  parameter int unsigned AFULL_LEVEL = 3
)
(
  input  logic             clk,
  input  logic             reset,
  input  word_t            in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output word_t            out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             almost_full
);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  word_t            words [DEPTH];

  // Flags are pure decodes of the occupancy count.
  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CNT_W'(AFULL_LEVEL));
  assign in_ready    = ~full;
  assign out_valid   = ~empty;

  // A transfer happens on each side only when both handshake halves are high.
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Storage: exactly one word loads per push, selected by the write pointer.
  for (genvar i = 0; i < DEPTH; i++) begin : g_store
    register_16 u_word (
      .clk   (clk),
      .reset (reset),
      .load  (push && (wr_ptr == PTR_W'(i))),
      .d     (in_data),
      .q     (words[i])
    );
  end

  // Head of the queue is the word under the read pointer.
  mux_4_way_16 u_head_mux (
    .a   (words[0]),
    .b   (words[1]),
    .c   (words[2]),
    .d   (words[3]),
    .sel (rd_ptr),
    .y   (out_data)
  );

  // Pointers wrap naturally at 2 bits; count tracks pushes minus pops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_4x16.sv
// Self-checking bench for fifo_4x16: directed vector table, hand sequences, random scoreboard.
module tb_fifo_4x16;

  logic        clk;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        almost_full;

  int checks;
  int failures;

  fifo_4x16 #(.AFULL_LEVEL(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] din;
    logic        ordy;
    logic [2:0]  e_count;
    logic        e_full;
    logic        e_afull;
    logic [15:0] e_head;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic iv, input logic [15:0] din, input logic ordy,
                         input logic [2:0] c, input logic f, input logic af, input logic [15:0] h);
    vecs[i].iv = iv; vecs[i].din = din; vecs[i].ordy = ordy;
    vecs[i].e_count = c; vecs[i].e_full = f; vecs[i].e_afull = af; vecs[i].e_head = h;
  endtask

  task automatic check_state(input string tag, input int exp_cnt, input logic [15:0] exp_head);
    check({tag, "_count"},     32'(count),       32'(exp_cnt));
    check({tag, "_out_valid"}, 32'(out_valid),   32'(exp_cnt != 0));
    check({tag, "_in_ready"},  32'(in_ready),    32'(exp_cnt != 4));
    check({tag, "_full"},      32'(full),        32'(exp_cnt == 4));
    check({tag, "_empty"},     32'(empty),       32'(exp_cnt == 0));
    check({tag, "_afull"},     32'(almost_full), 32'(exp_cnt >= 3));
    if (exp_cnt != 0) check({tag, "_head"}, 32'(out_data), 32'(exp_head));
  endtask

  initial begin
    logic [15:0] q [$];
    logic [15:0] wrap_words [6];
    logic [15:0] next_word;
    int pushed, popped, cycles;
    logic do_push, do_pop;

    checks = 0; failures = 0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;

    // Reset: outputs must be in the cleared state before any clock edge.
    reset = 1'b1;
    #2;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h0000);
    check("rst_afull", 32'(almost_full), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check_state("idle", 0, 16'h0000);
    check("idle_out_data", 32'(out_data), 32'h0000);

    // Directed table: inputs for one edge, expected state after it.
    set_vec( 0, 1, 16'hA001, 0, 1, 0, 0, 16'hA001);
    set_vec( 1, 0, 16'h0000, 1, 0, 0, 0, 16'h0000);
    set_vec( 2, 1, 16'h0001, 0, 1, 0, 0, 16'h0001);
    set_vec( 3, 1, 16'h0002, 0, 2, 0, 0, 16'h0001);
    set_vec( 4, 1, 16'h0003, 0, 3, 0, 1, 16'h0001);
    set_vec( 5, 1, 16'h0004, 0, 4, 1, 1, 16'h0001);
    set_vec( 6, 1, 16'hDEAD, 0, 4, 1, 1, 16'h0001);
    set_vec( 7, 1, 16'hDEAD, 0, 4, 1, 1, 16'h0001);
    set_vec( 8, 0, 16'h0000, 1, 3, 0, 1, 16'h0002);
    set_vec( 9, 0, 16'h0000, 1, 2, 0, 0, 16'h0003);
    set_vec(10, 0, 16'h0000, 1, 1, 0, 0, 16'h0004);
    set_vec(11, 0, 16'h0000, 1, 0, 0, 0, 16'h0000);
    set_vec(12, 1, 16'h0005, 0, 1, 0, 0, 16'h0005);
    set_vec(13, 1, 16'h0006, 0, 2, 0, 0, 16'h0005);
    set_vec(14, 1, 16'h0007, 1, 2, 0, 0, 16'h0006);
    set_vec(15, 1, 16'h0008, 0, 3, 0, 1, 16'h0006);
    set_vec(16, 1, 16'h0009, 0, 4, 1, 1, 16'h0006);
    set_vec(17, 1, 16'hDEAD, 1, 3, 0, 1, 16'h0007);
    set_vec(18, 0, 16'h0000, 1, 2, 0, 0, 16'h0008);
    set_vec(19, 0, 16'h0000, 1, 1, 0, 0, 16'h0009);
    set_vec(20, 0, 16'h0000, 1, 0, 0, 0, 16'h0000);

    for (int i = 0; i < 21; i++) begin
      in_valid = vecs[i].iv; in_data = vecs[i].din; out_ready = vecs[i].ordy;
      step();
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
      check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].e_full));
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(!vecs[i].e_full));
      check($sformatf("vec%0d_afull", i), 32'(almost_full), 32'(vecs[i].e_afull));
      check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].e_count == 3'd0));
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_count != 3'd0));
      if (vecs[i].e_count != 3'd0)
        check($sformatf("vec%0d_head", i), 32'(out_data), 32'(vecs[i].e_head));
    end
    in_valid = 1'b0; out_ready = 1'b0;

    // Wrap: count stays at or below 2 while pointers roll over.
    wrap_words[0] = 16'h1111; wrap_words[1] = 16'h2222; wrap_words[2] = 16'h3333;
    wrap_words[3] = 16'h4444; wrap_words[4] = 16'h5555; wrap_words[5] = 16'h6666;
    in_valid = 1'b1; in_data = wrap_words[0];
    step();
    check_state("wrap_first", 1, wrap_words[0]);
    for (int k = 1; k < 6; k++) begin
      in_data = wrap_words[k]; in_valid = 1'b1; out_ready = 1'b0;
      step();
      check_state($sformatf("wrap_push%0d", k), 2, wrap_words[k-1]);
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      check_state($sformatf("wrap_pop%0d", k), 1, wrap_words[k]);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check_state("wrap_drain", 0, 16'h0000);
    out_ready = 1'b0;

    // Asynchronous reset mid-stream with two words stored.
    in_valid = 1'b1; in_data = 16'hBEE1;
    step();
    in_data = 16'hBEE2;
    step();
    in_valid = 1'b0;
    check("mid_pre_count", 32'(count), 32'd2);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'h0000);
    @(negedge clk);
    reset = 1'b0;
    step();
    check_state("post_rst", 0, 16'h0000);

    // Random traffic against a queue model.
    q.delete();
    pushed = 0; popped = 0; cycles = 0;
    while ((pushed < 1000 || q.size() != 0) && cycles < 20000) begin
      check("rnd_count", 32'(count), 32'(q.size()));
      check("rnd_count_balance", 32'(count), 32'(pushed - popped));
      check("rnd_out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("rnd_in_ready", 32'(in_ready), 32'(q.size() < 4));
      if (q.size() != 0) check("rnd_head", 32'(out_data), 32'(q[0]));
      next_word = 16'($urandom);
      in_data   = next_word;
      in_valid  = (pushed < 1000) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      do_push = in_valid && (q.size() < 4);
      do_pop  = out_ready && (q.size() != 0);
      step();
      if (do_pop) begin
        void'(q.pop_front());
        popped++;
      end
      if (do_push) begin
        q.push_back(next_word);
        pushed++;
      end
      cycles++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("rnd_budget", 32'(cycles < 20000), 32'd1);
    check("rnd_pushed", 32'(pushed), 32'd1000);
    check("rnd_popped", 32'(popped), 32'd1000);
    check("rnd_final_empty", 32'(empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
